// File: rtl/serv_immenc.sv
// serv_immenc - bit-serial immediate encoder (inverse of the SERV immediate
// decoder). A 32-bit immediate arrives LSB-first in W-bit beats; once all
// 32/W beats are in, the immediate is scattered into the RV32I I/S/B/U/J
// instruction layout together with the latched opcode/funct3/register fields.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_start                 start request, only looked at in IDLE
//   i_fmt                   0=I 1=S 2=B 3=U 4=J, 5..7 illegal (encoded as I, ovf forced)
//   i_opcode/i_funct3/i_rd/i_rs1/i_rs2   instruction fields latched at start
//   i_imm_en, i_imm         beat valid and W-bit immediate beat (LSB-first)
//   o_busy                  high while beats are being collected
//   o_valid                 one-cycle pulse when o_insn/o_ovf become valid
//   o_insn                  encoded instruction, held until the next start
//   o_ovf                   immediate does not fit the selected format
module serv_immenc #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [2:0]   i_fmt,
    input  logic [6:0]   i_opcode,
    input  logic [2:0]   i_funct3,
    input  logic [4:0]   i_rd,
    input  logic [4:0]   i_rs1,
    input  logic [4:0]   i_rs2,
    input  logic         i_imm_en,
    input  logic [W-1:0] i_imm,
    output logic         o_busy,
    output logic         o_valid,
    output logic [31:0]  o_insn,
    output logic         o_ovf
);

    localparam int         NBEATS    = 32 / W;
    localparam logic [4:0] LAST_BEAT = 5'(NBEATS - 1);

    localparam logic [2:0] FMT_I = 3'd0;
    localparam logic [2:0] FMT_S = 3'd1;
    localparam logic [2:0] FMT_B = 3'd2;
    localparam logic [2:0] FMT_U = 3'd3;
    localparam logic [2:0] FMT_J = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [4:0]  cnt_r;
    logic [31:0] imm_r;
    logic [2:0]  fmt_r;
    logic [6:0]  opcode_r;
    logic [2:0]  funct3_r;
    logic [4:0]  rd_r;
    logic [4:0]  rs1_r;
    logic [4:0]  rs2_r;

    // Scatter the immediate into the instruction word for the given format.
    // Illegal formats fall back to the I layout.
    function automatic logic [31:0] enc_insn(
        input logic [2:0]  fmt,
        input logic [6:0]  opc,
        input logic [2:0]  f3,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        logic [31:0] insn;
        case (fmt)
            FMT_I:   insn = {imm[11:0], rs1, f3, rd, opc};
            FMT_S:   insn = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
            FMT_B:   insn = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
            FMT_U:   insn = {imm[31:12], rd, opc};
            FMT_J:   insn = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
            default: insn = {imm[11:0], rs1, f3, rd, opc};
        endcase
        return insn;
    endfunction

    // Range check: the bits above the top encoded bit must all be copies of
    // the sign bit; branch/jump offsets must also be even, and U immediates
    // must have their low 12 bits clear.
    function automatic logic ovf_of(
        input logic [2:0]  fmt,
        input logic [31:0] imm
    );
        logic ovf;
        case (fmt)
            FMT_I, FMT_S: ovf = !((&imm[31:11]) || (~|imm[31:11]));
            FMT_B:        ovf = imm[0] || !((&imm[31:12]) || (~|imm[31:12]));
            FMT_U:        ovf = |imm[11:0];
            FMT_J:        ovf = imm[0] || !((&imm[31:20]) || (~|imm[31:20]));
            default:      ovf = 1'b1;
        endcase
        return ovf;
    endfunction

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: DONE always lasts a single cycle and ignores start.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (i_imm_en && (cnt_r == LAST_BEAT)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Field latch at start, then beat collection: each accepted beat enters
    // at the top so after 32/W beats the first beat sits at bit 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r    <= 5'd0;
            imm_r    <= 32'd0;
            fmt_r    <= 3'd0;
            opcode_r <= 7'd0;
            funct3_r <= 3'd0;
            rd_r     <= 5'd0;
            rs1_r    <= 5'd0;
            rs2_r    <= 5'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_start) begin
                        cnt_r    <= 5'd0;
                        fmt_r    <= i_fmt;
                        opcode_r <= i_opcode;
                        funct3_r <= i_funct3;
                        rd_r     <= i_rd;
                        rs1_r    <= i_rs1;
                        rs2_r    <= i_rs2;
                    end
                end
                ST_SHIFT: begin
                    if (i_imm_en) begin
                        imm_r <= {i_imm, imm_r[31:W]};
                        cnt_r <= cnt_r + 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status decodes straight from the state register; the instruction word
    // is a pure function of registered fields, so it holds until the next
    // accepted start rewrites the latched fields.
    assign o_busy  = (state_r == ST_SHIFT);
    assign o_valid = (state_r == ST_DONE);
    assign o_insn  = enc_insn(fmt_r, opcode_r, funct3_r, rd_r, rs1_r, rs2_r, imm_r);
    assign o_ovf   = ovf_of(fmt_r, imm_r);

endmodule

// File: tb/tb_serv_immenc.sv
// Self-checking bench for serv_immenc. Three instances (W=1, 2, 4) share the
// clock and reset; each has its own stimulus signals. Expected instruction
// words and overflow flags come from an arithmetic model of the RV32I
// immediate layouts and value ranges.
module tb_serv_immenc;

    logic        clk;
    logic        rst_n;
    logic        start  [3];
    logic [2:0]  fmt    [3];
    logic [6:0]  opc    [3];
    logic [2:0]  f3     [3];
    logic [4:0]  rd     [3];
    logic [4:0]  rs1    [3];
    logic [4:0]  rs2    [3];
    logic        imm_en [3];
    logic [3:0]  imm_b  [3];
    logic        busy   [3];
    logic        valid  [3];
    logic [31:0] insn   [3];
    logic        ovf    [3];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serv_immenc #(.W(1)) u_w1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_fmt(fmt[0]),
        .i_opcode(opc[0]), .i_funct3(f3[0]), .i_rd(rd[0]), .i_rs1(rs1[0]),
        .i_rs2(rs2[0]), .i_imm_en(imm_en[0]), .i_imm(imm_b[0][0:0]),
        .o_busy(busy[0]), .o_valid(valid[0]), .o_insn(insn[0]), .o_ovf(ovf[0])
    );
    serv_immenc #(.W(2)) u_w2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_fmt(fmt[1]),
        .i_opcode(opc[1]), .i_funct3(f3[1]), .i_rd(rd[1]), .i_rs1(rs1[1]),
        .i_rs2(rs2[1]), .i_imm_en(imm_en[1]), .i_imm(imm_b[1][1:0]),
        .o_busy(busy[1]), .o_valid(valid[1]), .o_insn(insn[1]), .o_ovf(ovf[1])
    );
    serv_immenc #(.W(4)) u_w4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[2]), .i_fmt(fmt[2]),
        .i_opcode(opc[2]), .i_funct3(f3[2]), .i_rd(rd[2]), .i_rs1(rs1[2]),
        .i_rs2(rs2[2]), .i_imm_en(imm_en[2]), .i_imm(imm_b[2][3:0]),
        .o_busy(busy[2]), .o_valid(valid[2]), .o_insn(insn[2]), .o_ovf(ovf[2])
    );

    // Reference encoding built with shifts and masks on the field values.
    function automatic logic [31:0] model_insn(input int f, input int op, input int fn3,
                                               input int d, input int s1, input int s2,
                                               input logic [31:0] imm);
        logic [31:0] lo;
        lo = 32'((fn3 << 12) | op);
        case (f)
            1: return ((imm >> 5) & 32'h7F) << 25 | 32'(s2 << 20) | 32'(s1 << 15) | lo
                      | (imm & 32'h1F) << 7;
            2: return ((imm >> 12) & 32'h1) << 31 | ((imm >> 5) & 32'h3F) << 25
                      | 32'(s2 << 20) | 32'(s1 << 15) | lo
                      | ((imm >> 1) & 32'hF) << 8 | ((imm >> 11) & 32'h1) << 7;
            3: return (imm & 32'hFFFFF000) | 32'(d << 7) | 32'(op);
            4: return ((imm >> 20) & 32'h1) << 31 | ((imm >> 1) & 32'h3FF) << 21
                      | ((imm >> 11) & 32'h1) << 20 | ((imm >> 12) & 32'hFF) << 12
                      | 32'(d << 7) | 32'(op);
            default: return (imm & 32'hFFF) << 20 | 32'(s1 << 15) | lo | 32'(d << 7);
        endcase
    endfunction

    // Reference overflow: signed range and alignment of the immediate value.
    function automatic logic model_ovf(input int f, input logic [31:0] imm);
        int s;
        s = $signed(imm);
        case (f)
            0, 1: return (s < -2048) || (s > 2047);
            2:    return (imm % 2 != 0) || (s < -4096) || (s > 4095);
            3:    return (imm % 4096) != 0;
            4:    return (imm % 2 != 0) || (s < -(1 << 20)) || (s > (1 << 20) - 1);
            default: return 1'b1;
        endcase
    endfunction

    // Drive one complete transfer into instance k and record what was seen.
    task automatic xfer(input int k, input int f, input int op, input int fn3,
                        input int d, input int s1, input int s2, input logic [31:0] imm,
                        input int stall_at, input int stall_len, input bit noise,
                        input bit start_at_done,
                        output int busy_cnt, output int lat, output logic [31:0] got_insn,
                        output logic got_ovf, output logic busy_at_done,
                        output logic valid_next, output logic [31:0] held_insn,
                        output logic busy_next);
        int n;
        int w;
        logic [31:0] mask;
        n = 32 >> k;
        w = 1 << k;
        mask = (32'd1 << w) - 32'd1;
        @(negedge clk);
        start[k] = 1'b1;
        fmt[k] = 3'(f); opc[k] = 7'(op); f3[k] = 3'(fn3);
        rd[k] = 5'(d); rs1[k] = 5'(s1); rs2[k] = 5'(s2);
        @(negedge clk);
        start[k] = 1'b0;
        busy_cnt = 0;
        for (int b = 0; b < n; b++) begin
            if (b == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    imm_en[k] = 1'b0;
                    imm_b[k] = 4'($urandom);
                    if (busy[k] === 1'b1) busy_cnt++;
                    @(negedge clk);
                end
            end
            imm_en[k] = 1'b1;
            imm_b[k] = 4'((imm >> (b * w)) & mask);
            if (noise) begin
                start[k] = 1'($urandom);
                fmt[k] = 3'($urandom); opc[k] = 7'($urandom); f3[k] = 3'($urandom);
                rd[k] = 5'($urandom); rs1[k] = 5'($urandom); rs2[k] = 5'($urandom);
            end
            if (busy[k] === 1'b1) busy_cnt++;
            @(negedge clk);
        end
        imm_en[k] = 1'b0;
        start[k] = 1'b0;
        lat = -1;
        got_insn = 32'd0;
        got_ovf = 1'b0;
        busy_at_done = 1'b0;
        for (int t = 0; t < 4 && lat < 0; t++) begin
            if (valid[k] === 1'b1) begin
                lat = t;
                got_insn = insn[k];
                got_ovf = ovf[k];
                busy_at_done = busy[k];
                if (start_at_done) start[k] = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        valid_next = valid[k];
        held_insn = insn[k];
        busy_next = busy[k];
        if (!start_at_done) start[k] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0; imm_en[i] = 1'b0; imm_b[i] = 4'd0;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy[i] !== 1'b0 || valid[i] !== 1'b0 || insn[i] !== 32'h0 || ovf[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset[%0d]: busy=%b valid=%b insn=%08h ovf=%b, want 0 0 00000000 0",
                         i, busy[i], valid[i], insn[i], ovf[i]);
            end
        end
    endtask

    // Directed vector: checks word, flag, busy length, latency and hold.
    task automatic test_directed(input string tag, input int k, input int f, input int op,
                                 input int fn3, input int d, input int s1, input int s2,
                                 input logic [31:0] imm, input int stall_at, input int stall_len,
                                 input logic [31:0] want_insn, input logic want_ovf);
        int bc, lat;
        logic [31:0] gi, hi;
        logic go, bd, vn, bn;
        xfer(k, f, op, fn3, d, s1, s2, imm, stall_at, stall_len, 1'b0, 1'b0,
             bc, lat, gi, go, bd, vn, hi, bn);
        checks++;
        if (gi !== want_insn || gi !== model_insn(f, op, fn3, d, s1, s2, imm)) begin
            failures++;
            $display("FAIL %s insn: got %08h want %08h", tag, gi, want_insn);
        end
        checks++;
        if (go !== want_ovf) begin
            failures++;
            $display("FAIL %s ovf: got %b want %b", tag, go, want_ovf);
        end
        checks++;
        if (bc != (32 >> k) + stall_len || lat != 0 || bd !== 1'b0) begin
            failures++;
            $display("FAIL %s timing: busy_cycles=%0d lat=%0d busy_at_done=%b want %0d 0 0",
                     tag, bc, lat, bd, (32 >> k) + stall_len);
        end
        checks++;
        if (vn !== 1'b0 || hi !== want_insn || bn !== 1'b0) begin
            failures++;
            $display("FAIL %s after_done: valid=%b insn=%08h busy=%b want 0 %08h 0",
                     tag, vn, hi, bn, want_insn);
        end
    endtask

    // Start pulses and changing field inputs during SHIFT must not matter.
    task automatic test_start_during_shift();
        int bc, lat;
        logic [31:0] gi, hi, want;
        logic go, bd, vn, bn;
        want = model_insn(1, 7'h23, 3, 7, 9, 17, 32'hFFFFF830);
        xfer(1, 1, 7'h23, 3, 7, 9, 17, 32'hFFFFF830, -1, 0, 1'b1, 1'b0,
             bc, lat, gi, go, bd, vn, hi, bn);
        checks++;
        if (gi !== want || go !== 1'b0 || bc != 16 || lat != 0) begin
            failures++;
            $display("FAIL start_in_shift: insn=%08h ovf=%b busy=%0d lat=%0d want %08h 0 16 0",
                     gi, go, bc, lat, want);
        end
    endtask

    // A start held during DONE is ignored, then accepted the following cycle.
    task automatic test_done_start();
        int bc, lat;
        logic [31:0] gi, hi;
        logic go, bd, vn, bn;
        xfer(2, 0, 7'h13, 0, 4, 5, 0, 32'd100, -1, 0, 1'b0, 1'b1,
             bc, lat, gi, go, bd, vn, hi, bn);
        checks++;
        if (lat != 0 || bn !== 1'b0 || vn !== 1'b0) begin
            failures++;
            $display("FAIL done_start_ignored: lat=%0d busy_next=%b valid_next=%b want 0 0 0",
                     lat, bn, vn);
        end
        @(negedge clk);
        checks++;
        if (busy[2] !== 1'b1) begin
            failures++;
            $display("FAIL done_start_next: busy=%b want 1", busy[2]);
        end
        start[2] = 1'b0;
        do_reset();
    endtask

    // Asynchronous reset at beat 10 aborts with no o_valid.
    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        start[0] = 1'b1; fmt[0] = 3'd3; opc[0] = 7'h37; rd[0] = 5'd3;
        @(negedge clk);
        start[0] = 1'b0;
        for (int b = 0; b < 10; b++) begin
            imm_en[0] = 1'b1; imm_b[0] = 4'($urandom);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy[0] !== 1'b0 || valid[0] !== 1'b0 || insn[0] !== 32'h0 || ovf[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: busy=%b valid=%b insn=%08h ovf=%b want 0 0 00000000 0",
                     busy[0], valid[0], insn[0], ovf[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (valid[0] === 1'b1 || busy[0] === 1'b1) seen++;
        end
        imm_en[0] = 1'b0;
        checks++;
        if (seen != 0 || insn[0] !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_after: active_cycles=%0d insn=%08h want 0 00000000", seen, insn[0]);
        end
    endtask

    // Randomized transfers across widths, formats and boundary immediates.
    task automatic test_random();
        int edges[14] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, -4098,
                          (1 << 20) - 2, (1 << 20), -(1 << 20), -(1 << 20) - 2, 4095, 0};
        for (int it = 0; it < 60; it++) begin
            int k, f, op, fn3, d, s1, s2, sa, sl, bc, lat;
            logic [31:0] imm, gi, hi, wi;
            logic go, bd, vn, bn, wo;
            k = $urandom_range(0, 2);
            f = $urandom_range(0, 7);
            op = $urandom_range(0, 127); fn3 = $urandom_range(0, 7);
            d = $urandom_range(0, 31); s1 = $urandom_range(0, 31); s2 = $urandom_range(0, 31);
            case ($urandom_range(0, 3))
                0: imm = $urandom;
                1: imm = 32'($signed($urandom_range(0, 10000)) - 5000);
                2: imm = 32'(edges[$urandom_range(0, 13)]);
                default: imm = $urandom & 32'hFFFFF000;
            endcase
            sa = ($urandom_range(0, 1) == 1) ? $urandom_range(1, (32 >> k) - 1) : -1;
            sl = (sa >= 0) ? $urandom_range(1, 6) : 0;
            wi = model_insn(f, op, fn3, d, s1, s2, imm);
            wo = model_ovf(f, imm);
            xfer(k, f, op, fn3, d, s1, s2, imm, sa, sl, 1'($urandom), 1'b0,
                 bc, lat, gi, go, bd, vn, hi, bn);
            checks++;
            if (gi !== wi || go !== wo || lat != 0 || bc != (32 >> k) + sl || vn !== 1'b0) begin
                failures++;
                $display("FAIL random[%0d] W=%0d fmt=%0d imm=%08h: insn=%08h ovf=%b lat=%0d busy=%0d vnext=%b want %08h %b 0 %0d 0",
                         it, 1 << k, f, imm, gi, go, lat, bc, vn, wi, wo, (32 >> k) + sl);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0; fmt[i] = 3'd0; opc[i] = 7'd0; f3[i] = 3'd0;
            rd[i] = 5'd0; rs1[i] = 5'd0; rs2[i] = 5'd0; imm_en[i] = 1'b0; imm_b[i] = 4'd0;
        end
        test_reset();
        test_directed("i_w1",   0, 0, 7'h13, 0, 1, 2, 0, 32'hFFFFFFFF, -1, 0, 32'hFFF10093, 1'b0);
        test_directed("s_w1",   0, 1, 7'h23, 2, 0, 2, 5, 32'd8,        -1, 0, 32'h00512423, 1'b0);
        test_directed("j_w4",   2, 4, 7'h6F, 0, 1, 0, 0, 32'h800,      -1, 0, 32'h001000EF, 1'b0);
        test_directed("j_stall",2, 4, 7'h6F, 0, 1, 0, 0, 32'h800,       4, 5, 32'h001000EF, 1'b0);
        test_directed("u_w2",   1, 3, 7'h37, 0, 3, 0, 0, 32'h12345000, -1, 0, 32'h123451B7, 1'b0);
        test_directed("b_odd",  0, 2, 7'h63, 1, 0, 4, 6, 32'd3,        -1, 0,
                      model_insn(2, 7'h63, 1, 0, 4, 6, 32'd3), 1'b1);
        test_directed("fmt6",   1, 6, 7'h13, 5, 8, 9, 10, 32'd16,      -1, 0,
                      model_insn(0, 7'h13, 5, 8, 9, 10, 32'd16), 1'b1);
        test_start_during_shift();
        test_done_start();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
